// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stage controller: state encoding, stage
// bit positions and the enable/flush masks built from them.
package pipe_ctrl_pkg;

    localparam int unsigned NumStages   = 4;
    localparam int unsigned WaitCntBits = 8;

    // Stage register bit positions within StageEnable / StageFlush.
    localparam int unsigned IF_ID  = 0;
    localparam int unsigned ID_EX  = 1;
    localparam int unsigned EX_MEM = 2;
    localparam int unsigned MEM_WB = 3;

    typedef logic [NumStages-1:0] stage_mask_t;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalted  = 2'd2
    } state_e;

    function automatic stage_mask_t stage_bit(input int unsigned idx);
        return stage_mask_t'(1) << idx;
    endfunction

    localparam stage_mask_t EnAll     = '1;
    localparam stage_mask_t EnNone    = '0;
    localparam stage_mask_t EnLoadUse = stage_bit(EX_MEM) | stage_bit(MEM_WB);
    localparam stage_mask_t FlNone    = '0;
    localparam stage_mask_t FlBranch  = stage_bit(IF_ID) | stage_bit(ID_EX);
    // Load-use inserts a bubble into ID/EX while IF/ID holds.
    localparam stage_mask_t FlLoadUse = stage_bit(ID_EX);

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-high reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage controller: derives per-stage clock enables and flushes from
// hazards, memory handshakes and halt requests, with a memory-wait timeout.
module pipe_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                LoadUse,
    input  logic                BranchTaken,
    input  logic                MemReq,
    input  logic                MemAck,
    input  logic                Halt,
    input  logic                Resume,
    output logic [3:0]          StageEnable,
    output logic [3:0]          StageFlush,
    output logic                Busy,
    output logic                TimeoutFlag,
    output logic [CNT_BITS-1:0] StallCount,
    output logic [1:0]          State
);

    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : gen_bad_timeout
        $error("pipe_stage_ctrl: TIMEOUT must be within 1..255");
    end

    localparam logic [WaitCntBits-1:0] TimeoutCnt = WaitCntBits'(TIMEOUT);

    state_e                 state_d, state_q;
    logic [WaitCntBits-1:0] wait_cnt_d, wait_cnt_q;
    logic                   timeout_d, timeout_q;
    logic                   busy_q;
    stage_mask_t            stage_en, stage_fl;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        stage_en   = EnNone;
        stage_fl   = FlNone;

        if (Tick) begin
            if (Halt) begin
                // Halt wins over everything, including an ack in the same cycle.
                state_d    = StHalted;
                wait_cnt_d = '0;
            end else begin
                case (state_q)
                    StRun: begin
                        if (MemReq && !MemAck) begin
                            state_d    = StMemWait;
                            wait_cnt_d = WaitCntBits'(1);
                        end else if (BranchTaken) begin
                            stage_en = EnAll;
                            stage_fl = FlBranch;
                        end else if (LoadUse) begin
                            stage_en = EnLoadUse;
                            stage_fl = FlLoadUse;
                        end else begin
                            stage_en = EnAll;
                        end
                    end
                    StMemWait: begin
                        if (MemAck) begin
                            stage_en   = EnAll;
                            state_d    = StRun;
                            wait_cnt_d = '0;
                        end else if (wait_cnt_q == TimeoutCnt) begin
                            state_d    = StHalted;
                            timeout_d  = 1'b1;
                            wait_cnt_d = '0;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WaitCntBits'(1);
                        end
                    end
                    StHalted: begin
                        if (Resume) begin
                            state_d = StRun;
                        end
                    end
                    default: begin
                        state_d    = StRun;
                        wait_cnt_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            busy_q     <= (state_d != StRun);
        end
    end

    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_stall_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (Tick && (stage_en != EnAll)),
        .count (StallCount)
    );

    assign StageEnable = stage_en;
    assign StageFlush  = stage_fl;
    assign Busy        = busy_q;
    assign TimeoutFlag = timeout_q;
    assign State       = state_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed scenarios plus random traffic against a cycle-level reference model
// of the stage controller.
module tb_pipe_stage_ctrl;

    localparam int unsigned Timeout  = 4;
    localparam int unsigned CntBits  = 6;
    localparam int unsigned StallMax = (1 << CntBits) - 1;

    logic               Clock = 1'b0;
    logic               Reset, Tick, LoadUse, BranchTaken, MemReq, MemAck, Halt, Resume;
    logic [3:0]         StageEnable, StageFlush;
    logic               Busy, TimeoutFlag;
    logic [CntBits-1:0] StallCount;
    logic [1:0]         State;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: 0=RUN 1=MEM_WAIT 2=HALTED, waited = MEM_WAIT cycles without ack.
    int unsigned m_state, m_waited, m_stall;
    logic        m_flag;
    logic [3:0]  last_en, last_fl;

    always #5 Clock = ~Clock;

    pipe_stage_ctrl #(
        .TIMEOUT  (Timeout),
        .CNT_BITS (CntBits)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Tick        (Tick),
        .LoadUse     (LoadUse),
        .BranchTaken (BranchTaken),
        .MemReq      (MemReq),
        .MemAck      (MemAck),
        .Halt        (Halt),
        .Resume      (Resume),
        .StageEnable (StageEnable),
        .StageFlush  (StageFlush),
        .Busy        (Busy),
        .TimeoutFlag (TimeoutFlag),
        .StallCount  (StallCount),
        .State       (State)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_outputs(output logic [3:0] en, output logic [3:0] fl);
        en = 4'b0000;
        fl = 4'b0000;
        if (Tick && !Halt) begin
            if (m_state == 0) begin
                if (!(MemReq && !MemAck)) begin
                    en = 4'b1111;
                    if (BranchTaken) fl = 4'b0011;
                    else if (LoadUse) begin
                        en = 4'b1100;
                        fl = 4'b0010;
                    end
                end
            end else if (m_state == 1 && MemAck) begin
                en = 4'b1111;
            end
        end
    endfunction

    function automatic void model_clock(input logic [3:0] en);
        if (Reset) begin
            m_state  = 0;
            m_waited = 0;
            m_flag   = 1'b0;
            m_stall  = 0;
        end else if (Tick) begin
            if (en != 4'b1111 && m_stall < StallMax) m_stall++;
            if (Halt) m_state = 2;
            else if (m_state == 0) begin
                if (MemReq && !MemAck) begin
                    m_state  = 1;
                    m_waited = 0;
                end
            end else if (m_state == 1) begin
                if (MemAck) m_state = 0;
                else begin
                    m_waited++;
                    if (m_waited == Timeout) begin
                        m_state = 2;
                        m_flag  = 1'b1;
                    end
                end
            end else if (Resume) begin
                m_state = 0;
            end
        end
    endfunction

    task automatic cycle(input logic r, input logic t, input logic lu, input logic br,
                         input logic mq, input logic ma, input logic h, input logic rs);
        logic [3:0] e_en, e_fl;
        @(negedge Clock);
        Reset = r; Tick = t; LoadUse = lu; BranchTaken = br;
        MemReq = mq; MemAck = ma; Halt = h; Resume = rs;
        #1;
        model_outputs(e_en, e_fl);
        check_eq("stage_enable", 32'(StageEnable), 32'(e_en));
        check_eq("stage_flush", 32'(StageFlush), 32'(e_fl));
        last_en = StageEnable;
        last_fl = StageFlush;
        @(posedge Clock);
        model_clock(e_en);
        #1;
        check_eq("state", 32'(State), m_state);
        check_eq("busy", 32'(Busy), 32'(m_state != 0));
        check_eq("timeout_flag", 32'(TimeoutFlag), 32'(m_flag));
        check_eq("stall_count", 32'(StallCount), m_stall);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset = 1'b1; Tick = 1'b0; LoadUse = 1'b0; BranchTaken = 1'b0;
        MemReq = 1'b0; MemAck = 1'b0; Halt = 1'b0; Resume = 1'b0;
        m_state = 0; m_waited = 0; m_stall = 0; m_flag = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check_eq("rst_state", 32'(State), 0);
        check_eq("rst_busy", 32'(Busy), 0);
        check_eq("rst_stall", 32'(StallCount), 0);
        check_eq("rst_flag", 32'(TimeoutFlag), 0);

        // Quiet pipeline
        idle(5);
        check_eq("quiet_en", 32'(last_en), 32'hf);
        check_eq("quiet_stall", 32'(StallCount), 0);
        check_eq("quiet_state", 32'(State), 0);

        // Branch beats load-use
        cycle(0, 1, 1, 1, 0, 0, 0, 0);
        check_eq("br_lu_fl", 32'(last_fl), 32'h3);
        check_eq("br_lu_en", 32'(last_en), 32'hf);
        check_eq("br_lu_stall", 32'(StallCount), 0);
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
        check_eq("lu_en", 32'(last_en), 32'hc);
        check_eq("lu_fl", 32'(last_fl), 32'h2);

        // Three-cycle memory wait then ack
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 1, 0, 0, 0);
            check_eq("memwait_en", 32'(last_en), 0);
        end
        cycle(0, 1, 1, 1, 1, 1, 0, 0);
        check_eq("ack_en", 32'(last_en), 32'hf);
        check_eq("ack_fl", 32'(last_fl), 0);
        check_eq("ack_state", 32'(State), 0);
        check_eq("ack_stall", 32'(StallCount), 1 + 3);

        // Timeout: RUN request cycle then Timeout MEM_WAIT cycles
        cycle(0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < int'(Timeout) - 1; i++) cycle(0, 1, 0, 0, 1, 0, 0, 0);
        check_eq("pre_timeout_state", 32'(State), 1);
        check_eq("pre_timeout_flag", 32'(TimeoutFlag), 0);
        cycle(0, 1, 0, 0, 1, 0, 0, 0);
        check_eq("timeout_state", 32'(State), 2);
        check_eq("timeout_flag", 32'(TimeoutFlag), 1);
        cycle(0, 1, 0, 0, 0, 0, 1, 1);
        check_eq("halt_blocks_resume", 32'(State), 2);
        cycle(0, 1, 0, 0, 0, 0, 0, 1);
        check_eq("resume_state", 32'(State), 0);
        check_eq("resume_flag", 32'(TimeoutFlag), 1);

        // Tick low freezes a pending wait
        do_reset();
        check_eq("rst2_flag", 32'(TimeoutFlag), 0);
        cycle(0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, 1, 1, 0, 0, 0);
            check_eq("frozen_en", 32'(last_en), 0);
        end
        check_eq("frozen_state", 32'(State), 1);
        check_eq("frozen_stall", 32'(StallCount), 1);
        check_eq("frozen_flag", 32'(TimeoutFlag), 0);
        cycle(0, 1, 0, 0, 1, 1, 0, 0);
        check_eq("frozen_ack_state", 32'(State), 0);

        // Reset during the second MEM_WAIT cycle, late ack afterwards
        cycle(0, 1, 0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 1, 0, 0);
        check_eq("late_ack_state", 32'(State), 0);
        check_eq("late_ack_en", 32'(last_en), 32'hf);
        check_eq("late_ack_fl", 32'(last_fl), 0);
        check_eq("late_ack_stall", 32'(StallCount), 0);

        // Halt overrides an ack in the same cycle
        cycle(0, 1, 0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 1, 1, 0);
        check_eq("halt_over_ack_en", 32'(last_en), 0);
        check_eq("halt_over_ack_state", 32'(State), 2);

        // Stall counter saturation
        do_reset();
        for (int i = 0; i < int'(StallMax) + 8; i++) cycle(0, 1, 0, 0, 0, 0, 1, 0);
        check_eq("stall_sat", 32'(StallCount), StallMax);
        cycle(0, 1, 0, 0, 0, 0, 0, 1);
        check_eq("stall_sat_hold", 32'(StallCount), StallMax);

        // Random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(299) == 0),
                  ($urandom_range(9) < 8),
                  ($urandom_range(3) == 0),
                  ($urandom_range(5) == 0),
                  ($urandom_range(2) == 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(24) == 0),
                  ($urandom_range(3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_ctrl.md
PIPE_STAGE_CTRL -- requirements
Module: pipe_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: MEM_WAIT Tick-cycles before a bus timeout is declared; legal range 1..255.
REQ-002 Parameter CNT_BITS, default 16: width of the stall performance counter.
REQ-003 Clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Tick  in  1  global advance qualifier; when 0, no state, counter or output-enable activity.
REQ-006 LoadUse  in  1  load-use hazard detected in ID.
REQ-007 BranchTaken  in  1  branch/jump resolved taken in EX.
REQ-008 MemReq  in  1  MEM stage issuing a data-memory access this cycle.
REQ-009 MemAck  in  1  data memory completes the access this cycle.
REQ-010 Halt  in  1  halt request from the debug/control path.
REQ-011 Resume  in  1  leave HALTED.
REQ-012 StageEnable  out  4  ClockEnable for pipeline registers; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
REQ-013 StageFlush  out  4  one-cycle clear for the same registers, same bit mapping.
REQ-014 Busy  out  1  high when state is not RUN.
REQ-015 TimeoutFlag  out  1  sticky memory-timeout indicator.
REQ-016 StallCount  out  CNT_BITS  saturating count of Tick cycles with any StageEnable bit 0.
REQ-017 State  out  2  encoding RUN=0, MEM_WAIT=1, HALTED=2; value 3 is unreachable.

Function
REQ-018 StageEnable and StageFlush SHALL be combinational in the registered state and current inputs; both SHALL be 0 whenever Tick=0.
REQ-019 Input priority in RUN SHALL be Halt > memory stall > BranchTaken > LoadUse.
REQ-020 RUN with no event: StageEnable=4'b1111, StageFlush=0.
REQ-021 RUN, MemReq=1, MemAck=0: StageEnable=0; next state MEM_WAIT; wait counter loads 1.
REQ-022 RUN, MemReq=1, MemAck=1: treated as no event (zero-wait access).
REQ-023 RUN, BranchTaken: StageEnable=4'b1111, StageFlush=4'b0011; state stays RUN.
REQ-024 RUN, LoadUse only: StageEnable=4'b1100, StageFlush=4'b0010 (bubble into ID/EX); state stays RUN.
REQ-025 MEM_WAIT, MemAck=0: StageEnable=0; wait counter increments per Tick; when the counter equals TIMEOUT, next state HALTED and TimeoutFlag sets.
REQ-026 MEM_WAIT, MemAck=1: StageEnable=4'b1111, StageFlush=0; next state RUN; BranchTaken/LoadUse are ignored in that cycle.
REQ-027 Halt=1 with Tick=1 in any state: StageEnable=0; next state HALTED; Halt overrides a MemAck arriving in the same cycle.
REQ-028 HALTED: StageEnable=0; on Resume=1 with Halt=0, next state RUN; TimeoutFlag persists until Reset.
REQ-029 StallCount SHALL increment on every Tick cycle in which StageEnable != 4'b1111 and SHALL saturate at all-ones.
REQ-030 Busy SHALL be a registered copy of (next state != RUN), so it equals (State != RUN).

Reset
REQ-031 Reset (synchronous, highest priority, independent of Tick): State=RUN, wait counter=0, TimeoutFlag=0, StallCount=0, Busy=0.
REQ-032 Reset asserted mid-MEM_WAIT SHALL abandon the wait with no flush; a late MemAck after reset is ignored.

Structure
REQ-033 State encodings, stage bit indices (IF_ID=0 to MEM_WB=3) and the enable/flush constants SHALL live in shared package pipe_ctrl_pkg.
REQ-034 The saturating StallCount counter SHALL be a sub-module sat_counter (parameter WIDTH; inputs Clock, Reset, inc).

Verification
REQ-035 Reset, then 5 Tick cycles with no events -> StageEnable=4'b1111, StallCount=0, State=0.
REQ-036 LoadUse=1 and BranchTaken=1 together for 1 cycle -> StageFlush=4'b0011, StageEnable=4'b1111, StallCount unchanged.
REQ-037 MemReq=1, MemAck held low 3 Tick cycles, then high -> enables 0 for 3 cycles, 4'b1111 on the ack cycle, State back to 0, StallCount=3.
REQ-038 TIMEOUT=4, MemReq with no ack -> HALTED after the 4th wait cycle, TimeoutFlag=1; Resume -> RUN with TimeoutFlag still 1.
REQ-039 Tick=0 during MEM_WAIT for 10 cycles -> counter and State frozen, no timeout.
REQ-040 Reset pulsed at the 2nd MEM_WAIT cycle, then MemAck=1 -> State=0, StageEnable=4'b1111, StallCount=0, no flush.
